// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: decouples I-cache fetch packets (1 or 2 words)
// from decode, which consumes up to two instructions per cycle in program
// order. A redirect flush empties the queue; reset clears it asynchronously.
module inst_fetch_queue #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [63:0] in_data,
    output logic [1:0]  out_valid,
    output logic [31:0] out_pc0,
    output logic [31:0] out_inst0,
    output logic [31:0] out_pc1,
    output logic [31:0] out_inst1,
    input  logic [1:0]  deq_num
);

    localparam int CNT_W = PTR_W + 1;

    // Entry storage is deliberately left without reset; occupancy lives in
    // the pointer/count registers only.
    logic [31:0]      pc_mem_r   [DEPTH];
    logic [31:0]      inst_mem_r [DEPTH];

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    logic [PTR_W-1:0] head_p1_s;
    logic [PTR_W-1:0] tail_p1_s;
    logic             in_ready_s;
    logic             enq_fire_s;
    logic [1:0]       enq_n_s;
    logic [1:0]       deq_clamp_s;
    logic [1:0]       eff_deq_s;
    logic [CNT_W-1:0] count_next_s;

    // Pointer increments wrap naturally because DEPTH is a power of two.
    assign head_p1_s = head_r + PTR_W'(1);
    assign tail_p1_s = tail_r + PTR_W'(1);

    // Acceptance looks only at registered occupancy, so space freed by this
    // cycle's dequeue is not reusable until the next cycle.
    assign in_ready_s = (count_r <= CNT_W'(DEPTH - 2));
    assign enq_fire_s = in_valid & in_ready_s & ~flush;

    // Packet size and dequeue clamping (3 behaves as 2, never below empty).
    always_comb begin
        enq_n_s     = 2'd0;
        deq_clamp_s = 2'd0;
        eff_deq_s   = 2'd0;
        if (enq_fire_s) begin
            enq_n_s = in_pc[2] ? 2'd1 : 2'd2;
        end else begin
            enq_n_s = 2'd0;
        end
        case (deq_num)
            2'd0:    deq_clamp_s = 2'd0;
            2'd1:    deq_clamp_s = 2'd1;
            2'd2:    deq_clamp_s = 2'd2;
            default: deq_clamp_s = 2'd2;
        endcase
        if (CNT_W'(deq_clamp_s) > count_r) begin
            eff_deq_s = count_r[1:0];
        end else begin
            eff_deq_s = deq_clamp_s;
        end
    end

    assign count_next_s = count_r + CNT_W'(enq_n_s) - CNT_W'(eff_deq_s);

    // Pointer and occupancy update; flush overrides any same-cycle traffic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            head_r  <= head_r + PTR_W'(eff_deq_s);
            tail_r  <= tail_r + PTR_W'(enq_n_s);
            count_r <= count_next_s;
        end
    end

    // Entry writes: an aligned packet fills two consecutive slots (possibly
    // straddling the last index), an odd-word packet fills one slot.
    always_ff @(posedge clk) begin
        if (enq_fire_s) begin
            if (!in_pc[2]) begin
                pc_mem_r[tail_r]      <= in_pc;
                inst_mem_r[tail_r]    <= in_data[31:0];
                pc_mem_r[tail_p1_s]   <= in_pc + 32'd4;
                inst_mem_r[tail_p1_s] <= in_data[63:32];
            end else begin
                pc_mem_r[tail_r]      <= in_pc;
                inst_mem_r[tail_r]    <= in_data[63:32];
            end
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid[0] = (count_r >= CNT_W'(1));
    assign out_valid[1] = (count_r >= CNT_W'(2));
    assign out_pc0      = pc_mem_r[head_r];
    assign out_inst0    = inst_mem_r[head_r];
    assign out_pc1      = pc_mem_r[head_p1_s];
    assign out_inst1    = inst_mem_r[head_p1_s];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: a vector table with hand-computed
// occupancy results, plus a reference queue of expected {pc, inst} entries
// compared against the decode slots every cycle.
module tb_inst_fetch_queue;

    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [63:0] in_data;
    logic [1:0]  out_valid;
    logic [31:0] out_pc0;
    logic [31:0] out_inst0;
    logic [31:0] out_pc1;
    logic [31:0] out_inst1;
    logic [1:0]  deq_num;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic [63:0] data;
        logic [1:0]  dq;
        logic [1:0]  ev;
        logic        er;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    vec_t   vecs[$];
    entry_t sb[$];
    int     checks = 0;
    int     passed = 0;

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_pc0   (out_pc0),
        .out_inst0 (out_inst0),
        .out_pc1   (out_pc1),
        .out_inst1 (out_inst1),
        .deq_num   (deq_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic fl, input logic iv, input logic [31:0] pc,
                                input logic [63:0] data, input logic [1:0] dq,
                                input logic [1:0] ev, input logic er);
        vec_t v;
        v.fl = fl; v.iv = iv; v.pc = pc; v.data = data; v.dq = dq; v.ev = ev; v.er = er;
        vecs.push_back(v);
    endfunction

    // Compare decode slots and handshake against the reference queue.
    task automatic sb_check();
        int n;
        n = sb.size();
        chk("sb_valid", {62'd0, out_valid}, {62'd0, (n >= 2), (n >= 1)});
        chk("sb_ready", {63'd0, in_ready}, {63'd0, ((DEPTH - n) >= 2)});
        if (n >= 1) begin
            chk("slot0_pc", {32'd0, out_pc0}, {32'd0, sb[0].pc});
            chk("slot0_inst", {32'd0, out_inst0}, {32'd0, sb[0].inst});
        end
        if (n >= 2) begin
            chk("slot1_pc", {32'd0, out_pc1}, {32'd0, sb[1].pc});
            chk("slot1_inst", {32'd0, out_inst1}, {32'd0, sb[1].inst});
        end
    endtask

    // Advance the reference queue by one clock edge.
    task automatic model_step(input vec_t v);
        int n;
        int d;
        entry_t e;
        n = sb.size();
        if (v.fl) begin
            sb.delete();
        end else begin
            d = (v.dq == 2'd3) ? 2 : int'(v.dq);
            if (d > n) d = n;
            for (int k = 0; k < d; k++) void'(sb.pop_front());
            if (v.iv && ((DEPTH - n) >= 2)) begin
                if (!v.pc[2]) begin
                    e.pc = v.pc;          e.inst = v.data[31:0];  sb.push_back(e);
                    e.pc = v.pc + 32'd4;  e.inst = v.data[63:32]; sb.push_back(e);
                end else begin
                    e.pc = v.pc;          e.inst = v.data[63:32]; sb.push_back(e);
                end
            end
        end
    endtask

    task automatic cycle(input vec_t v);
        flush = v.fl; in_valid = v.iv; in_pc = v.pc; in_data = v.data; deq_num = v.dq;
        @(negedge clk);
        sb_check();
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = 32'd0; in_data = 64'd0; deq_num = 2'd0;

        // Basic, unaligned, over-dequeue, redundant deq_num=3.
        add(1'b0, 1'b1, 32'h1000, 64'hBBBB0000_AAAA0000, 2'd0, 2'b11, 1'b1);
        add(1'b0, 1'b0, 32'h0,    64'h0,                 2'd2, 2'b00, 1'b1);
        add(1'b0, 1'b1, 32'h2004, 64'h12345678_DEADBEEF, 2'd0, 2'b01, 1'b1);
        add(1'b0, 1'b0, 32'h0,    64'h0,                 2'd2, 2'b00, 1'b1);
        add(1'b0, 1'b1, 32'h3000, 64'h00003004_00003000, 2'd0, 2'b11, 1'b1);
        add(1'b0, 1'b0, 32'h0,    64'h0,                 2'd3, 2'b00, 1'b1);
        // Fill to full, hold a packet, free space, accept the held packet.
        add(1'b0, 1'b1, 32'h4000, 64'h40040000_40000000, 2'd0, 2'b11, 1'b1);
        add(1'b0, 1'b1, 32'h4008, 64'h400C0000_40080000, 2'd0, 2'b11, 1'b1);
        add(1'b0, 1'b1, 32'h4010, 64'h40140000_40100000, 2'd0, 2'b11, 1'b1);
        add(1'b0, 1'b1, 32'h4018, 64'h401C0000_40180000, 2'd0, 2'b11, 1'b0);
        add(1'b0, 1'b1, 32'h4020, 64'h40240000_40200000, 2'd0, 2'b11, 1'b0);
        add(1'b0, 1'b1, 32'h4020, 64'h40240000_40200000, 2'd2, 2'b11, 1'b1);
        add(1'b0, 1'b1, 32'h4020, 64'h40240000_40200000, 2'd0, 2'b11, 1'b0);
        add(1'b0, 1'b0, 32'h0,    64'h0,                 2'd2, 2'b11, 1'b1);
        add(1'b0, 1'b0, 32'h0,    64'h0,                 2'd2, 2'b11, 1'b1);
        add(1'b0, 1'b0, 32'h0,    64'h0,                 2'd2, 2'b11, 1'b1);
        add(1'b0, 1'b0, 32'h0,    64'h0,                 2'd2, 2'b00, 1'b1);
        // Streaming two-in/two-out across the index wrap.
        for (int i = 0; i < 10; i++) begin
            add(1'b0, 1'b1, 32'h100 + 32'(8 * i), {32'hC000_0000 + 32'(i), 32'hA000_0000 + 32'(i)},
                2'd2, 2'b11, 1'b1);
        end
        add(1'b0, 1'b0, 32'h0,    64'h0,                 2'd2, 2'b00, 1'b1);
        // Build count=5, then flush with simultaneous enqueue and dequeue.
        add(1'b0, 1'b1, 32'h5000, 64'h50040000_50000000, 2'd0, 2'b11, 1'b1);
        add(1'b0, 1'b1, 32'h5008, 64'h500C0000_50080000, 2'd0, 2'b11, 1'b1);
        add(1'b0, 1'b1, 32'h5014, 64'h50140000_DEAD0000, 2'd0, 2'b11, 1'b1);
        add(1'b1, 1'b1, 32'h6000, 64'h60040000_60000000, 2'd1, 2'b00, 1'b1);
        add(1'b0, 1'b1, 32'h7000, 64'h70040000_70000000, 2'd0, 2'b11, 1'b1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_valid", {62'd0, out_valid}, 64'd0);
        chk("reset_ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i]);
            chk($sformatf("vec%0d_valid", i), {62'd0, out_valid}, {62'd0, vecs[i].ev});
            chk($sformatf("vec%0d_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].er});
        end

        // Asynchronous reset in the middle of an enqueue, checked before any edge.
        flush = 1'b0; in_valid = 1'b1; in_pc = 32'h8000; in_data = 64'h80040000_80000000; deq_num = 2'd0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", {62'd0, out_valid}, 64'd0);
        chk("async_rst_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        v.fl = 1'b0; v.iv = 1'b1; v.pc = 32'h9000; v.data = 64'h90040000_90000000; v.dq = 2'd0;
        v.ev = 2'b11; v.er = 1'b1;
        cycle(v);
        chk("post_rst_valid", {62'd0, out_valid}, 64'd3);
        v.iv = 1'b0; v.dq = 2'd1;
        cycle(v);
        chk("post_rst_deq1", {62'd0, out_valid}, 64'd1);
        v.dq = 2'd0;
        cycle(v);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Decoupling instruction queue between the I-cache response path (fetch) and decode.
- Accepts fetch packets of 1 or 2 instructions per cycle. Packet size follows the pre-fetch PC rule: an 8-byte-aligned PC yields 2 instructions; PC[2]=1 yields 1.
- Presents the two oldest instructions to decode in program order.
- Decode retires 0–2 per cycle; a redirect flush empties the queue.

Parameters:
- DEPTH, 8, number of instruction entries; power of 2, >= 4.
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = asserted).
- flush  in  1  redirect; discard all queued entries.
- in_valid  in  1  fetch packet valid.
- in_ready  out  1  queue can accept a full packet (free entries >= 2).
- in_pc  in  32  PC of first instruction in packet.
- in_data  in  64  I-cache line half: [31:0] = word at PC with PC[2]=0, [63:32] = word at PC with PC[2]=1.
- out_valid  out  2  bit0: slot0 valid; bit1: slot1 valid (bit1 implies bit0).
- out_pc0  out  32  PC of oldest entry.
- out_inst0  out  32  instruction of oldest entry.
- out_pc1  out  32  PC of second-oldest entry.
- out_inst1  out  32  instruction of second-oldest entry.
- deq_num  in  2  number of instructions decode consumes this cycle (0, 1, 2; 3 treated as 2).

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, inst}.
  - head_ptr and tail_ptr are PTR_W bits and wrap modulo DEPTH.
  - count is PTR_W+1 bits, range 0..DEPTH.
- Reset (reset=0, async): head_ptr=0, tail_ptr=0, count=0, so out_valid=2'b00 and in_ready=1. Entry storage is not reset.
- Enqueue fire = in_valid & in_ready.
  - in_pc[2]=0: write {in_pc, in_data[31:0]} then {in_pc+4, in_data[63:32]}; tail += 2.
  - in_pc[2]=1: write {in_pc, in_data[63:32]}; tail += 1.
  - in_valid while in_ready=0: ignored; fetch must hold the packet.
- in_ready = (DEPTH - count) >= 2. Computed combinationally from registered count only; no dependence on deq_num.
- Outputs are combinational reads of registered state:
  - out_valid[0] = count>=1; out_valid[1] = count>=2.
  - Slot0 = entry[head], slot1 = entry[head+1 mod DEPTH].
  - When a slot is invalid, its pc/inst values are don't-care.
- Dequeue: eff_deq = min(deq_num clamped to 2, count); head += eff_deq. Over-requests are silently clamped and never underflow.
- Simultaneous enqueue and dequeue in one cycle: count_next = count + enq_n - eff_deq.
  - Legal at any occupancy, because in_ready is evaluated before the dequeue.
  - Freed entries are not reusable in the same cycle.
- Latency: an instruction enqueued at edge N appears on out_* after edge N (first visible cycle N+1). There is no bypass from in_* to out_*.
- Flush has top priority. On the next edge head=tail=0 and count=0, and any same-cycle enqueue and dequeue are discarded. out_valid=0 the cycle after flush.
- Wrap-around: pairs may straddle index DEPTH-1 → 0; slot1 reads index (head+1) mod DEPTH.
- Program order is preserved: the PC sequence presented equals the enqueue order.
- Reset mid-operation: immediate async clear; contents lost regardless of flush/in_valid.

Test Plan:
1. Reset release, DEPTH=8: out_valid=00, in_ready=1. Enqueue in_pc=0x1000, in_data=0xBBBB0000_AAAA0000 → next cycle out_valid=11, slot0 {0x1000, 0xAAAA0000}, slot1 {0x1004, 0xBBBB0000}.
2. Unaligned packet: in_pc=0x2004, in_data=0x12345678_DEADBEEF → only 1 entry added: {0x2004, 0x12345678}; out_valid=01 if queue was empty.
3. Fill with 3 aligned packets (count=6): in_ready=1. 4th packet → count=8, in_ready=0. A 5th packet held with in_valid=1 and deq_num=0 is not written. deq_num=2 for one cycle → count=6, in_ready=1, and the held packet is accepted the following edge.
4. Wrap: enqueue/dequeue 2 per cycle for 10 cycles, PCs 0x100, 0x108, … → slot PCs strictly sequential, count constant at 2, no loss across index 7→0.
5. count=1 with deq_num=2 → eff_deq=1, count=0, out_valid=00, no pointer corruption. A subsequent aligned enqueue reads back correctly.
6. count=5 with same-cycle flush=1, in_valid=1, deq_num=1 → next cycle count=0, out_valid=00. Then assert reset=0 asynchronously mid-enqueue → out_valid=00 immediately, without waiting for an edge.
